mux_channel_scanner: RTL and testbench

- Sequential front-end for the 4:1 select mux (s1, s0, d0..d3 -> o).
- Drives the mux's s1/s0 and walks through the enabled data channels in ascending order, then samples the mux output for each one.
- Assembles the sampled bits into a 4-bit snapshot word, with a start/done handshake and optional continuous rescanning.
- Sits directly upstream of the mux (drives the selects) and downstream of it (captures o).

---
 rtl/mux_channel_scanner_if.sv | 24 ++
 rtl/mux_channel_scanner.sv | 145 ++++++++++++++
 tb/tb_mux_channel_scanner.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mux_channel_scanner_if.sv
// Handshake and mux-side signals between a scan controller and its environment.
// The master modport is the environment (requester plus the mux itself); the scanner is the slave.
interface mux_channel_scanner_if;
    logic       start;
    logic       continuous;
    logic [3:0] en_mask;
    logic       mux_o;
    logic       s1;
    logic       s0;
    logic       busy;
    logic       done;
    logic [3:0] sample;
    logic       changed;

    modport master (
        output start, continuous, en_mask, mux_o,
        input  s1, s0, busy, done, sample, changed
    );

    modport slave (
        input  start, continuous, en_mask, mux_o,
        output s1, s0, busy, done, sample, changed
    );
endinterface

// File: rtl/mux_channel_scanner.sv
// Walks the enabled inputs of a 4:1 mux in ascending order, samples its output for each
// and commits the bits into a snapshot word with a start/done handshake.
module mux_channel_scanner #(
    parameter int unsigned SETTLE_CYCLES = 0,
    parameter int unsigned CNT_W         = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    mux_channel_scanner_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
    localparam state_e           FIRST_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_e           state_q, state_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0]       scratch_q, scratch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             done_q, done_d;
    logic [3:0]       sample_q, sample_d;
    logic             changed_q, changed_d;

    logic [3:0]       scratch_w;
    logic [3:0]       higher_w;
    logic [3:0]       commit_w;

    function automatic logic [1:0] lowest_idx(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Channels strictly above idx; empty above 3, so the walk never wraps.
    function automatic logic [3:0] above_mask(input logic [1:0] idx);
        case (idx)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1100;
            2'd2:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case infers a latch.
        state_d   = state_q;
        mask_d    = mask_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        done_d    = 1'b0;
        sample_d  = sample_q;
        changed_d = changed_q;

        scratch_w        = scratch_q;
        scratch_w[sel_q] = bus.mux_o;
        higher_w         = mask_q & above_mask(sel_q);
        commit_w         = (sample_q & ~mask_q) | (scratch_w & mask_q);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.en_mask != 4'b0000) begin
                        mask_d  = bus.en_mask;
                        sel_d   = lowest_idx(bus.en_mask);
                        cnt_d   = SETTLE_LOAD;
                        state_d = FIRST_STATE;
                    end else begin
                        done_d    = 1'b1;
                        changed_d = 1'b0;
                    end
                end
            end

            SETTLE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                scratch_d = scratch_w;
                if (higher_w != 4'b0000) begin
                    sel_d   = lowest_idx(higher_w);
                    cnt_d   = SETTLE_LOAD;
                    state_d = FIRST_STATE;
                end else begin
                    sample_d  = commit_w;
                    changed_d = (commit_w != sample_q);
                    done_d    = 1'b1;
                    // The mask is relatched only here, so mid-scan mask edits never leak in.
                    if (bus.continuous && (bus.en_mask != 4'b0000)) begin
                        mask_d  = bus.en_mask;
                        sel_d   = lowest_idx(bus.en_mask);
                        cnt_d   = SETTLE_LOAD;
                        state_d = FIRST_STATE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mask_q    <= 4'b0000;
            scratch_q <= 4'b0000;
            cnt_q     <= '0;
            sel_q     <= 2'd0;
            done_q    <= 1'b0;
            sample_q  <= 4'b0000;
            changed_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
            state_q   <= state_d;
            mask_q    <= mask_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            done_q    <= done_d;
            sample_q  <= sample_d;
            changed_q <= changed_d;
        end
    end

    assign bus.s1      = sel_q[1];
    assign bus.s0      = sel_q[0];
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.sample  = sample_q;
    assign bus.changed = changed_q;

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Directed bench for mux_channel_scanner: one instance with no settle time, one with two
// settle cycles, each fed by a behavioural 4:1 mux model.
module tb_mux_channel_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dat0 = 4'b0000;
    logic [3:0] dat2 = 4'b0000;
    int         checks = 0;
    int         errors = 0;

    mux_channel_scanner_if if0 ();
    mux_channel_scanner_if if2 ();

    assign if0.mux_o = dat0[{if0.s1, if0.s0}];
    assign if2.mux_o = dat2[{if2.s1, if2.s0}];

    mux_channel_scanner #(.SETTLE_CYCLES(0), .CNT_W(4)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    mux_channel_scanner #(.SETTLE_CYCLES(2), .CNT_W(4)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        if0.start = 1'b0; if0.continuous = 1'b0; if0.en_mask = 4'b0000;
        if2.start = 1'b0; if2.continuous = 1'b0; if2.en_mask = 4'b0000;

        // Reset state
        repeat (3) cyc();
        check("rst_sel",     {if0.s1, if0.s0}, 2'b00);
        check("rst_busy",    if0.busy, 1'b0);
        check("rst_done",    if0.done, 1'b0);
        check("rst_sample",  if0.sample, 4'b0000);
        check("rst_changed", if0.changed, 1'b0);
        rst_n = 1'b1;
        cyc();

        // Full scan, no settle: d0..d3 = 1,0,1,1
        dat0 = 4'b1101; if0.en_mask = 4'b1111; if0.start = 1'b1;
        cyc();
        if0.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("full_sel",  {if0.s1, if0.s0}, i);
            check("full_busy", if0.busy, 1'b1);
            check("full_done", if0.done, 1'b0);
            cyc();
        end
        check("full_done_hi", if0.done, 1'b1);
        check("full_busy_lo", if0.busy, 1'b0);
        check("full_sample",  if0.sample, 4'b1101);
        check("full_changed", if0.changed, 1'b1);
        cyc();
        check("full_done_pulse", if0.done, 1'b0);
        check("full_sel_hold",   {if0.s1, if0.s0}, 2'b11);

        // Sparse mask 0101 with d0=0, d2=0: bits 1 and 3 keep their old values
        dat0 = 4'b1010; if0.en_mask = 4'b0101; if0.start = 1'b1;
        cyc();
        if0.start = 1'b0;
        check("sparse_sel0", {if0.s1, if0.s0}, 2'b00);
        cyc();
        check("sparse_sel2", {if0.s1, if0.s0}, 2'b10);
        check("sparse_busy", if0.busy, 1'b1);
        cyc();
        check("sparse_done",    if0.done, 1'b1);
        check("sparse_sample",  if0.sample, 4'b1000);
        check("sparse_changed", if0.changed, 1'b1);

        // Empty mask: one-cycle done, no busy, sample untouched
        if0.en_mask = 4'b0000; if0.start = 1'b1;
        cyc();
        if0.start = 1'b0;
        check("empty_done",    if0.done, 1'b1);
        check("empty_busy",    if0.busy, 1'b0);
        check("empty_changed", if0.changed, 1'b0);
        check("empty_sample",  if0.sample, 4'b1000);
        cyc();
        check("empty_done_pulse", if0.done, 1'b0);
        check("empty_busy2",      if0.busy, 1'b0);

        // Continuous rescans of mask 0011, then drop continuous mid-scan
        dat0 = 4'b0011; if0.en_mask = 4'b0011; if0.continuous = 1'b1; if0.start = 1'b1;
        cyc();
        if0.start = 1'b0;
        check("cont_busy_a", if0.busy, 1'b1);
        cyc();
        cyc();
        check("cont_done1",    if0.done, 1'b1);
        check("cont_busy1",    if0.busy, 1'b1);
        check("cont_sample1",  if0.sample, 4'b1011);
        check("cont_changed1", if0.changed, 1'b1);
        cyc();
        check("cont_gap_done", if0.done, 1'b0);
        check("cont_gap_busy", if0.busy, 1'b1);
        cyc();
        check("cont_done2",    if0.done, 1'b1);
        check("cont_changed2", if0.changed, 1'b0);
        if0.continuous = 1'b0; if0.en_mask = 4'b1111; dat0 = 4'b0001;
        cyc();
        check("cont_last_sel",  {if0.s1, if0.s0}, 2'b01);
        check("cont_last_busy", if0.busy, 1'b1);
        check("cont_last_done", if0.done, 1'b0);
        cyc();
        check("cont_done3",    if0.done, 1'b1);
        check("cont_busy3",    if0.busy, 1'b0);
        check("cont_sample3",  if0.sample, 4'b1001);
        check("cont_changed3", if0.changed, 1'b1);
        check("cont_sel_hold", {if0.s1, if0.s0}, 2'b01);
        cyc();
        check("cont_idle_done", if0.done, 1'b0);
        check("cont_idle_busy", if0.busy, 1'b0);

        // Two settle cycles, single channel 1, run twice with the same data
        for (int run = 0; run < 2; run++) begin
            dat2 = 4'b0010; if2.en_mask = 4'b0010; if2.start = 1'b1;
            cyc();
            if2.start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                check("settle_sel",  {if2.s1, if2.s0}, 2'b01);
                check("settle_busy", if2.busy, 1'b1);
                check("settle_done", if2.done, 1'b0);
                cyc();
            end
            check("settle_done_hi", if2.done, 1'b1);
            check("settle_sample",  if2.sample, 4'b0010);
            check("settle_changed", if2.changed, (run == 0) ? 1'b1 : 1'b0);
        end
        cyc();

        // Async reset between the 2nd and 3rd sample of a full scan
        dat0 = 4'b1111; if0.en_mask = 4'b1111; if0.start = 1'b1;
        cyc();
        if0.start = 1'b0;
        cyc();
        cyc();
        check("abort_sel_pre", {if0.s1, if0.s0}, 2'b10);
        rst_n = 1'b0;
        #1;
        check("abort_sel",     {if0.s1, if0.s0}, 2'b00);
        check("abort_busy",    if0.busy, 1'b0);
        check("abort_done",    if0.done, 1'b0);
        check("abort_sample",  if0.sample, 4'b0000);
        check("abort_changed", if0.changed, 1'b0);
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("abort_no_done", if0.done, 1'b0);
            check("abort_idle",    if0.busy, 1'b0);
        end

        // Clean rescan after the abort
        dat0 = 4'b0101; if0.start = 1'b1;
        cyc();
        if0.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rescan_sel", {if0.s1, if0.s0}, i);
            cyc();
        end
        check("rescan_done",    if0.done, 1'b1);
        check("rescan_sample",  if0.sample, 4'b0101);
        check("rescan_changed", if0.changed, 1'b1);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
